// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA raster definitions: default 640x480@60 timing, counter width and small helpers
// used by the sync generator and by downstream display stages for range checks.
package vga_sync_gen_pkg;

  localparam int CNT_W   = 10;
  localparam int CNT_MAX = 1 << CNT_W;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  typedef logic [CNT_W-1:0] cnt_t;

  // One raster sample as it travels down the delay line; all-zero is the idle/blank state.
  typedef struct packed {
    logic h;
    logic v;
    logic vis;
  } raster_t;

  localparam raster_t RASTER_IDLE = '{h: 1'b0, v: 1'b0, vis: 1'b0};

  function automatic int timing_total(input int active, input int fp, input int sync,
                                      input int bp);
    return active + fp + sync + bp;
  endfunction

  // Half-open window test [lo, hi) on an unsigned counter value.
  function automatic logic in_window(input cnt_t cnt, input int lo, input int hi);
    return (int'(cnt) >= lo) && (int'(cnt) < hi);
  endfunction

  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_sync_gen_pix_divider.sv
// Pixel-rate divider: div_cnt cycles 0..CLK_DIV-1 and pix_en is a registered one-clk pulse
// in the clk following the terminal count (continuously high when CLK_DIV is 1).
module vga_pix_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_en
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end else begin
      pix_en <= (div_cnt == DIV_LAST);
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing source: pixel enable, x/y counters, line/frame strobes, and
// hsync/vsync/video_on delayed by PIPE_DLY pixel ticks to line up with the colour path.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = 1'b0,
  parameter int   PIPE_DLY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_en,
  output logic [9:0] x_cnt,
  output logic [9:0] y_cnt,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL      = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL      = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

  if (H_TOTAL > CNT_MAX) begin : g_bad_h_total
    $error("vga_sync_gen: H_TOTAL %0d does not fit the 10-bit counter", H_TOTAL);
  end
  if (V_TOTAL > CNT_MAX) begin : g_bad_v_total
    $error("vga_sync_gen: V_TOTAL %0d does not fit the 10-bit counter", V_TOTAL);
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_sync_gen: CLK_DIV %0d must be at least 1", CLK_DIV);
  end
  if ((PIPE_DLY < 0) || (PIPE_DLY > 4)) begin : g_bad_pipe_dly
    $error("vga_sync_gen: PIPE_DLY %0d outside 0..4", PIPE_DLY);
  end

  vga_pix_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_divider (
    .clk   (clk),
    .rst_n (rst_n),
    .pix_en(pix_en)
  );

  // Strobes are registered alongside the wrap so they coincide with the new count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt       <= '0;
      y_cnt       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        if (x_cnt == H_LAST) begin
          x_cnt      <= '0;
          line_start <= 1'b1;
          if (y_cnt == V_LAST) begin
            y_cnt       <= '0;
            frame_start <= 1'b1;
          end else begin
            y_cnt <= y_cnt + 10'd1;
          end
        end else begin
          x_cnt <= x_cnt + 10'd1;
        end
      end
    end
  end

  raster_t raw;
  raster_t dly_out;

  always_comb begin
    raw     = RASTER_IDLE;
    raw.h   = in_window(x_cnt, H_SYNC_START, H_SYNC_END);
    raw.v   = in_window(y_cnt, V_SYNC_START, V_SYNC_END);
    raw.vis = in_window(x_cnt, 0, H_ACTIVE) && in_window(y_cnt, 0, V_ACTIVE);
  end

  if (PIPE_DLY == 0) begin : g_no_dly
    // Counters sit at (0,0) in reset, which is visible; force blank so reset stays dark.
    assign dly_out = rst_n ? raw : RASTER_IDLE;
  end else begin : g_dly
    for (genvar i = 0; i < PIPE_DLY; i++) begin : g_stage
      raster_t d;
      raster_t q;
      if (i == 0) begin : g_first
        assign d = raw;
      end else begin : g_next
        assign d = g_stage[i-1].q;
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= RASTER_IDLE;
        end else if (pix_en) begin
          q <= d;
        end
      end
    end
    assign dly_out = g_stage[PIPE_DLY-1].q;
  end

  assign video_on = dly_out.vis;
  assign hsync    = sync_level(dly_out.h, SYNC_POL);
  assign vsync    = sync_level(dly_out.v, SYNC_POL);

endmodule
